// File: rtl/dp_pkg.sv
// Shared types and constants for datapath_pipe: ALU/shifter opcodes, flag bit positions
// and the control-word field layout.
package dp_pkg;

  typedef enum logic [2:0] {
    ALU_INC = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_DEC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_NOT = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_PASS = 2'd0,
    SH_SRL  = 2'd1,
    SH_SLL  = 2'd2,
    SH_ROR  = 2'd3
  } shift_op_t;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_W = 4;

  // LSB offsets of every control-word field; width is the total word size
  typedef struct packed {
    int unsigned a;
    int unsigned b;
    int unsigned d;
    int unsigned we;
    int unsigned mb;
    int unsigned g;
    int unsigned h;
    int unsigned mf;
    int unsigned md;
    int unsigned width;
  } cw_off_t;

  function automatic cw_off_t cw_offsets(input int unsigned rw);
    cw_off_t o;
    o.md    = 0;
    o.mf    = 1;
    o.h     = 2;
    o.g     = 4;
    o.mb    = 8;
    o.we    = 9;
    o.d     = 10;
    o.b     = 10 + rw;
    o.a     = 10 + 2 * rw;
    o.width = 10 + 3 * rw;
    return o;
  endfunction

endpackage

// File: rtl/dp_alu_shift.sv
// Combinational ALU with {C,V,N,Z} flags plus a one-bit shifter on the Y operand.
module dp_alu_shift
  import dp_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      y,
  input  logic [3:0]        g,
  input  logic [1:0]        h,
  output logic [N-1:0]      alu_out,
  output logic [N-1:0]      shift_out,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned NW = N + 1;

  logic [N-1:0] opnd;
  logic [N:0]   sum;
  logic         arith;

  // Arithmetic ops share one N+1 bit adder; only the second operand changes
  always_comb begin
    opnd    = '0;
    arith   = 1'b1;
    alu_out = '0;
    case (alu_op_t'(g[3:1]))
      ALU_INC: opnd = '0;
      ALU_ADD: opnd = y;
      ALU_SUB: opnd = ~y;
      ALU_DEC: opnd = '1;
      default: arith = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, opnd} + NW'(g[0]);
    case (alu_op_t'(g[3:1]))
      ALU_AND: alu_out = a & y;
      ALU_OR:  alu_out = a | y;
      ALU_XOR: alu_out = a ^ y;
      ALU_NOT: alu_out = ~a;
      default: alu_out = sum[N-1:0];
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_C] = arith & sum[N];
    flags[FLAG_V] = arith & (a[N-1] == opnd[N-1]) & (sum[N-1] != a[N-1]);
    flags[FLAG_N] = alu_out[N-1];
    flags[FLAG_Z] = (alu_out == '0);
  end

  always_comb begin
    shift_out = y;
    case (shift_op_t'(h))
      SH_PASS: shift_out = y;
      SH_SRL:  shift_out = {1'b0, y[N-1:1]};
      SH_SLL:  shift_out = {y[N-2:0], 1'b0};
      SH_ROR:  shift_out = {y[0], y[N-1:1]};
      default: shift_out = y;
    endcase
  end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage (issue / execute-retire) datapath with register file and valid/ready handshakes.
// Define DATAPATH_FORWARD_EN to bypass the retiring result into issue instead of stalling.
module datapath_pipe
  import dp_pkg::*;
#(
  parameter int unsigned   N         = 4,
  parameter int unsigned   NREG      = 4,
  parameter logic [N-1:0]  CONST_VAL = '1,
  localparam int unsigned  RW        = $clog2(NREG),
  // A, B, D, we, mb_sel, G[4], H[2], mf_sel, md_sel occupy 3*RW+10 bits
  localparam int unsigned  CW        = 3 * RW + 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CW-1:0]     ctrl_word,
  input  logic [N-1:0]      data_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N-1:0]      result,
  output logic [N-1:0]      address_out,
  output logic [N-1:0]      data_out,
  output logic [FLAG_W-1:0] state_bits
);

  localparam cw_off_t OFF = cw_offsets(RW);

  logic [RW-1:0] f_a, f_b, f_d;
  logic          f_we, f_mb, f_mf, f_md;
  logic [3:0]    f_g;
  logic [1:0]    f_h;

  assign f_a  = ctrl_word[OFF.a +: RW];
  assign f_b  = ctrl_word[OFF.b +: RW];
  assign f_d  = ctrl_word[OFF.d +: RW];
  assign f_we = ctrl_word[OFF.we];
  assign f_mb = ctrl_word[OFF.mb];
  assign f_g  = ctrl_word[OFF.g +: 4];
  assign f_h  = ctrl_word[OFF.h +: 2];
  assign f_mf = ctrl_word[OFF.mf];
  assign f_md = ctrl_word[OFF.md];

  logic [N-1:0]      rf_q [NREG];
  logic              rdy_q;
  logic              e_valid_q, e_we_q, e_mf_q, e_md_q;
  logic [RW-1:0]     e_d_q;
  logic [3:0]        e_g_q;
  logic [1:0]        e_h_q;
  logic [N-1:0]      e_a_q, e_y_q, e_din_q;
  logic [FLAG_W-1:0] flags_q;

  logic [N-1:0]      alu_out, shift_out, f2;
  logic [FLAG_W-1:0] alu_flags;
  logic [N-1:0]      ra_d, rb_d, y_d;
  logic              retire, issue, hazard;

  dp_alu_shift #(.N(N)) u_alu_shift (
    .a         (e_a_q),
    .y         (e_y_q),
    .g         (e_g_q),
    .h         (e_h_q),
    .alu_out   (alu_out),
    .shift_out (shift_out),
    .flags     (alu_flags)
  );

  assign f2     = e_md_q ? e_din_q : (e_mf_q ? shift_out : alu_out);
  assign retire = e_valid_q && res_ready;
  assign issue  = cmd_valid && cmd_ready;

`ifdef DATAPATH_FORWARD_EN
  // The retiring writeback is visible to the command issuing on the same edge
  assign ra_d   = (retire && e_we_q && (e_d_q == f_a)) ? f2 : rf_q[f_a];
  assign rb_d   = (retire && e_we_q && (e_d_q == f_b)) ? f2 : rf_q[f_b];
  assign hazard = 1'b0;
`else
  assign ra_d   = rf_q[f_a];
  assign rb_d   = rf_q[f_b];
  assign hazard = e_valid_q && e_we_q && ((e_d_q == f_a) || (f_mb && (e_d_q == f_b)));
`endif

  assign y_d       = f_mb ? rb_d : CONST_VAL;
  assign cmd_ready = rdy_q && (!e_valid_q || res_ready) && !hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      e_valid_q <= 1'b0;
      e_we_q    <= 1'b0;
      e_mf_q    <= 1'b0;
      e_md_q    <= 1'b0;
      e_d_q     <= '0;
      e_g_q     <= '0;
      e_h_q     <= '0;
      e_a_q     <= '0;
      e_y_q     <= '0;
      e_din_q   <= '0;
      flags_q   <= '0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (retire) begin
        if (e_we_q) rf_q[e_d_q] <= f2;
        if (!e_mf_q && !e_md_q) flags_q <= alu_flags;
      end
      if (issue) begin
        e_valid_q <= 1'b1;
        e_we_q    <= f_we;
        e_mf_q    <= f_mf;
        e_md_q    <= f_md;
        e_d_q     <= f_d;
        e_g_q     <= f_g;
        e_h_q     <= f_h;
        e_a_q     <= ra_d;
        e_y_q     <= y_d;
        e_din_q   <= data_in;
      end else if (retire) begin
        e_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid   = e_valid_q;
  assign result      = f2;
  assign address_out = e_a_q;
  assign data_out    = e_y_q;
  assign state_bits  = flags_q;

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe (N=4, NREG=4) against a sequential architectural model.
module tb_datapath_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] ctrl_word;
  logic [3:0]  data_in;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  result;
  logic [3:0]  address_out;
  logic [3:0]  data_out;
  logic [3:0]  state_bits;

  int checks = 0;
  int errors = 0;

`ifdef DATAPATH_FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  datapath_pipe #(.N(4), .NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .ctrl_word   (ctrl_word),
    .data_in     (data_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .address_out (address_out),
    .data_out    (data_out),
    .state_bits  (state_bits)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] res;
    logic [3:0] a;
    logic [3:0] y;
    logic [3:0] fl;
    logic       upd;
  } exp_t;

  logic [3:0] m_rf [4];
  logic [3:0] m_flags;
  exp_t       exp_q [$];

  function automatic logic [15:0] mk_cw(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] d, input logic we, input logic mb,
                                        input logic [3:0] g, input logic [1:0] h,
                                        input logic mf, input logic md);
    return {a, b, d, we, mb, g, h, mf, md};
  endfunction

  function automatic int sgn4(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  // Architectural ALU: integer arithmetic on 4-bit values
  function automatic void ref_alu(input int a, input int y, input int op, input int cin,
                                  output int r, output logic [3:0] fl);
    int o, t, s;
    bit c, v;
    c = 1'b0; v = 1'b0; o = 0; r = 0;
    if (op < 4) begin
      case (op)
        0: o = 0;
        1: o = y;
        2: o = 15 - y;
        default: o = 15;
      endcase
      t = a + o + cin;
      r = t % 16;
      c = (t > 15);
      s = sgn4(a) + sgn4(o) + cin;
      v = (s > 7) || (s < -8);
    end else begin
      case (op)
        4: r = a & y;
        5: r = a | y;
        6: r = a ^ y;
        default: r = 15 - a;
      endcase
    end
    fl = {c, v, (r >= 8), (r == 0)};
  endfunction

  function automatic int ref_shift(input int y, input int h);
    case (h)
      0: return y;
      1: return y / 2;
      2: return (y * 2) % 16;
      default: return y / 2 + (y % 2) * 8;
    endcase
  endfunction

  // Commands take effect in program order; writeback is applied to the model at issue
  task automatic model_issue(input logic [15:0] cw, input logic [3:0] din);
    int ra, y, r, sh, f2;
    logic [3:0] fl;
    exp_t e;
    ra = int'(m_rf[cw[15:14]]);
    y  = cw[8] ? int'(m_rf[cw[13:12]]) : 15;
    ref_alu(ra, y, int'(cw[7:5]), int'(cw[4]), r, fl);
    sh = ref_shift(y, int'(cw[3:2]));
    f2 = cw[0] ? int'(din) : (cw[1] ? sh : r);
    if (cw[9]) m_rf[cw[11:10]] = 4'(f2);
    e.res = 4'(f2);
    e.a   = 4'(ra);
    e.y   = 4'(y);
    e.fl  = fl;
    e.upd = !cw[1] && !cw[0];
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
    m_flags = 4'h0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, sample 1ns later, then cross the rising edge
  task automatic step(input logic v, input logic [15:0] cw, input logic [3:0] din,
                      input logic rr, output logic issued);
    exp_t e;
    @(negedge clk);
    cmd_valid = v;
    ctrl_word = cw;
    data_in   = din;
    res_ready = rr;
    #1;
    checks++;
    if (state_bits !== m_flags) begin
      errors++;
      $display("FAIL state_bits: got %b expected %b at %0t", state_bits, m_flags, $time);
    end
    checks++;
    if (res_valid !== (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL res_valid: got %b expected %b at %0t", res_valid, exp_q.size() != 0, $time);
    end
    if (res_valid === 1'b1 && rr && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (result !== e.res || address_out !== e.a || data_out !== e.y) begin
        errors++;
        $display("FAIL retire: got res=%h addr=%h dout=%h expected res=%h addr=%h dout=%h at %0t",
                 result, address_out, data_out, e.res, e.a, e.y, $time);
      end
      if (e.upd) m_flags = e.fl;
    end
    issued = v && (cmd_ready === 1'b1);
    if (issued) model_issue(cw, din);
    @(posedge clk);
  endtask

  task automatic send(input logic [15:0] cw, input logic [3:0] din, output int stalls);
    logic issued;
    issued = 1'b0;
    stalls = 0;
    for (int k = 0; k < 20 && !issued; k++) begin
      step(1'b1, cw, din, 1'b1, issued);
      if (!issued) stalls++;
    end
    checks++;
    if (!issued) begin
      errors++;
      $display("FAIL send_timeout: got no issue expected issue within 20 cycles, cw=%h", cw);
    end
  endtask

  task automatic drain();
    logic issued;
    for (int k = 0; k < 6 && exp_q.size() != 0; k++) step(1'b0, 16'h0, 4'h0, 1'b1, issued);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; ctrl_word = '0; data_in = '0; res_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || result !== 4'h0 || address_out !== 4'h0 ||
        data_out !== 4'h0 || state_bits !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b r=%h a=%h d=%h s=%b expected all 0",
               res_valid, result, address_out, data_out, state_bits);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: got %b expected 0", cmd_ready);
    end
    @(posedge clk);
    #2;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clock: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_load();
    int st;
    send(mk_cw(2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1), 4'h5, st);
    #2;
    checks++;
    if (res_valid !== 1'b1 || result !== 4'h5) begin
      errors++;
      $display("FAIL load_result: got v=%b r=%h expected v=1 r=5", res_valid, result);
    end
    drain();
    #2;
    checks++;
    if (state_bits !== 4'h0) begin
      errors++;
      $display("FAIL load_flags: got %b expected 0000", state_bits);
    end
  endtask

  task automatic test_dependent();
    int st;
    send(mk_cw(2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1), 4'h5, st);
    send(mk_cw(2'd1, 2'd1, 2'd2, 1'b1, 1'b1, 4'b0010, 2'd0, 1'b0, 1'b0), 4'h0, st);
    checks++;
    if (st != EXP_STALL) begin
      errors++;
      $display("FAIL dep_stall: got %0d stall cycles expected %0d", st, EXP_STALL);
    end
    #2;
    checks++;
    if (result !== 4'hA) begin
      errors++;
      $display("FAIL dep_result: got %h expected a", result);
    end
    drain();
    #2;
    checks++;
    if (state_bits !== 4'b0110) begin
      errors++;
      $display("FAIL dep_flags: got %b expected 0110", state_bits);
    end
  endtask

  task automatic test_const();
    int st;
    send(mk_cw(2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0010, 2'd0, 1'b0, 1'b0), 4'h0, st);
    #2;
    checks++;
    if (data_out !== 4'hF || result !== 4'h4) begin
      errors++;
      $display("FAIL const_path: got dout=%h r=%h expected dout=f r=4", data_out, result);
    end
    drain();
    #2;
    checks++;
    if (state_bits !== 4'b1000) begin
      errors++;
      $display("FAIL const_flags: got %b expected 1000", state_bits);
    end
  endtask

  task automatic test_backpressure();
    int st;
    logic [3:0] old_r2;
    logic [15:0] rd_cw;
    exp_t e;
    old_r2 = m_rf[2];
    send(mk_cw(2'd1, 2'd0, 2'd2, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0), 4'h0, st);
    e = exp_q[0];
    rd_cw = mk_cw(2'd2, 2'd2, 2'd0, 1'b0, 1'b1, 4'b1100, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b1; ctrl_word = rd_cw; data_in = 4'h0; res_ready = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || result !== e.res ||
          address_out !== e.a || data_out !== e.y || dut.rf_q[2] !== old_r2) begin
        errors++;
        $display("FAIL backpressure: got rdy=%b v=%b r=%h a=%h d=%h R2=%h expected rdy=0 v=1 r=%h a=%h d=%h R2=%h",
                 cmd_ready, res_valid, result, address_out, data_out, dut.rf_q[2],
                 e.res, e.a, e.y, old_r2);
      end
    end
    send(rd_cw, 4'h0, st);
    drain();
    checks++;
    if (dut.rf_q[2] !== m_rf[2]) begin
      errors++;
      $display("FAIL bp_writeback: got R2=%h expected %h", dut.rf_q[2], m_rf[2]);
    end
  endtask

  task automatic test_random();
    logic issued, v, rr;
    logic [15:0] cw;
    logic [3:0] din;
    int wait_cnt;
    wait_cnt = 0;
    cw = 16'h0; din = 4'h0;
    for (int n = 0; n < 400; n++) begin
      if (wait_cnt == 0) begin
        cw  = 16'($urandom);
        din = 4'($urandom);
      end
      v  = ($urandom_range(0, 9) < 8) || (wait_cnt != 0);
      rr = ($urandom_range(0, 3) != 0);
      step(v, cw, din, rr, issued);
      if (v && !issued) wait_cnt++;
      else wait_cnt = 0;
      if (wait_cnt > 30) begin
        checks++;
        errors++;
        $display("FAIL random_stuck: got no issue for %0d cycles expected progress", wait_cnt);
        break;
      end
    end
    drain();
  endtask

  task automatic test_reset_midop();
    int st;
    send(mk_cw(2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 4'b0111, 2'd0, 1'b0, 1'b0), 4'h0, st);
    drain();
    send(mk_cw(2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1), 4'h9, st);
    #2;
    checks++;
    if (res_valid !== 1'b1 || state_bits[3] !== 1'b1) begin
      errors++;
      $display("FAIL midop_setup: got v=%b C=%b expected v=1 C=1", res_valid, state_bits[3]);
    end
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (res_valid !== 1'b0 || state_bits !== 4'h0 || result !== 4'h0 || dut.rf_q[3] !== 4'h0) begin
      errors++;
      $display("FAIL midop_reset: got v=%b s=%b r=%h R3=%h expected 0 0 0 0",
               res_valid, state_bits, result, dut.rf_q[3]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(mk_cw(2'd3, 2'd3, 2'd0, 1'b0, 1'b1, 4'b0010, 2'd0, 1'b0, 1'b0), 4'h0, st);
    #2;
    checks++;
    if (address_out !== 4'h0) begin
      errors++;
      $display("FAIL midop_r3: got %h expected 0", address_out);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_load();
    test_dependent();
    test_const();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
